inc_stream_checker: RTL and testbench
=====================================

# inc_stream_checker

Closed-loop stimulus source and checker for the registered +1 data path on the Red Pitaya fabric. It drives a counting 14-bit stream into the increment stage and receives the stage's output. It compares each returned sample against the sent sample plus one, after a fixed pipeline latency. It reports pass/fail, a saturating error count and the first mismatch for readout over the register interface.

## Interface
- WIDTH, 14, sample width (ADC/DAC word).
- LATENCY, 1, cycles from `stim_o` to the matching `resp_i`; legal range 1..16.
- CNT_WIDTH, 32, width of the sample-count, error-count and index fields.

Ports:
- clk_i  in  1  fabric clock; all logic on its rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  one-cycle start request; accepted only in IDLE.
- seed_i  in  WIDTH  first stimulus value; captured on accepted start.
- num_samples_i  in  CNT_WIDTH  number of stimulus samples N; captured on accepted start.
- stim_o  out  WIDTH  stimulus to the increment stage input.
- resp_i  in  WIDTH  increment stage output.
- busy_o  out  1  high in RUN and DRAIN.
- done_o  out  1  one-cycle pulse in DONE.
- pass_o  out  1  1 when the last run finished with zero errors; held until the next start.
- err_count_o  out  CNT_WIDTH  mismatches in the current or last run; saturates at all-ones.
- first_err_idx_o  out  CNT_WIDTH  sample index k of the first mismatch.
- first_err_data_o  out  WIDTH  `resp_i` value at the first mismatch.

## Operation
- FSM states and transitions:
  - IDLE → RUN on `start_i` when N > 0.
  - IDLE → DONE on `start_i` when N == 0.
  - RUN → DRAIN after sample N-1 is issued.
  - DRAIN → DONE after the last comparison.
  - DONE → IDLE unconditionally.
- On an accepted start:
  - Clear `err_count_o`, `pass_o`, `first_err_idx_o` and `first_err_data_o`.
  - Capture `seed_i` and `num_samples_i`.
- Stimulus:
  - In RUN cycle k (k = 0..N-1), `stim_o` = (seed + k) mod 2^WIDTH; the sequence wraps from all-ones to 0.
  - Outside RUN, `stim_o` = 0.
- Expected value: a LATENCY-deep delay line carries (stim, valid) per sample.
  - At the tap, expected = (stim + 1) mod 2^WIDTH, compared unsigned over the full WIDTH.
  - Only taps with valid = 1 are compared.
- Mismatch handling:
  - Increment `err_count_o`, saturating at all-ones.
  - On the first mismatch of the run only, load `first_err_idx_o` = k and `first_err_data_o` = `resp_i`.
- DONE: `pass_o` ← (err_count == 0); assert `done_o`.
- Start handling: `start_i` in RUN, DRAIN or DONE is ignored and not queued.
- Reset, including mid-run:
  - FSM → IDLE and the delay line is cleared.
  - All outputs → 0: `stim_o`, `busy_o`, `done_o`, `pass_o`, `err_count_o`, `first_err_idx_o`, `first_err_data_o`.

## Timing
- Start accepted at edge t: the first RUN cycle (k = 0) is t+1, and `stim_o` = seed from t+1.
- The response for sample k is sampled in relative cycle k + LATENCY.
- Last comparison is at relative cycle N-1+LATENCY.
- DONE at relative cycle N+LATENCY: `done_o` = 1 for that cycle and `busy_o` = 0.
- IDLE at relative cycle N+LATENCY+1; a new start is accepted from then on.
- `busy_o` is high for N+LATENCY cycles.
- Status outputs:
  - `err_count_o` updates the cycle after the failing comparison.
  - `pass_o` is valid in the `done_o` cycle and afterwards.
- N == 0: `done_o` the cycle after start, `pass_o` = 1, `err_count_o` = 0, no stimulus issued.
- All outputs are registered; there is no combinational path from `resp_i` to any output.

## Test plan
- Loopback through a registered +1 stage, LATENCY=1, seed=100, N=10:
  - `stim_o` = 100..109.
  - `done_o` at relative cycle 11, `pass_o` = 1, `err_count_o` = 0.
- Wrap-around, seed=16380, N=8:
  - `stim_o` = 16380, 16381, 16382, 16383, 0, 1, 2, 3.
  - Expected values wrap 16383 → 0; `pass_o` = 1.
- Error injection on samples k=3 and k=6 (response forced to 0x0000), N=10:
  - `err_count_o` = 2, `first_err_idx_o` = 3, `first_err_data_o` = 0, `pass_o` = 0.
- LATENCY=4 with a 4-stage +1 model, N=5: `busy_o` high 9 cycles, `done_o` at relative cycle 9, `pass_o` = 1.
- N=0: `done_o` one cycle after start, `pass_o` = 1; `start_i` pulsed mid-run in a separate run is ignored (the run length is unchanged).
- `rst_i` asserted at k=2 of a 10-sample run:
  - Next cycle, all outputs = 0 and FSM in IDLE.
  - A following start, seed=0, N=3 passes.

Source files
------------

// File: rtl/inc_stream_checker.sv
// inc_stream_checker: drives a counting stream into a +1 stage and checks
// each returned sample against (sent + 1) after a fixed pipeline latency.
module inc_stream_checker #(
   parameter int WIDTH     = 14,
   parameter int LATENCY   = 1,
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic [WIDTH-1:0]     seed_i,
   input  logic [CNT_WIDTH-1:0] num_samples_i,
   output logic [WIDTH-1:0]     stim_o,
   input  logic [WIDTH-1:0]     resp_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 pass_o,
   output logic [CNT_WIDTH-1:0] err_count_o,
   output logic [CNT_WIDTH-1:0] first_err_idx_o,
   output logic [WIDTH-1:0]     first_err_data_o
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t state_q, state_d;

   logic [CNT_WIDTH-1:0]            n_q;        // captured sample count
   logic [CNT_WIDTH-1:0]            k_q;        // index of sample being issued
   logic [CNT_WIDTH-1:0]            cmp_idx_q;  // index of sample at the tap
   logic [LATENCY-1:0]              vld_pipe;
   logic [LATENCY-1:0][WIDTH-1:0]   stim_pipe;

   logic                 start_ok;
   logic                 last_issue;
   logic                 tap_vld;
   logic [WIDTH-1:0]     tap_exp;
   logic                 mism;
   logic                 last_cmp;
   logic [CNT_WIDTH-1:0] err_d;

   assign start_ok   = (state_q == S_IDLE) && start_i;
   assign last_issue = (state_q == S_RUN) && (k_q == n_q - CNT_WIDTH'(1));
   assign tap_vld    = vld_pipe[LATENCY-1];
   assign tap_exp    = stim_pipe[LATENCY-1] + WIDTH'(1);
   assign mism       = tap_vld && (resp_i != tap_exp);
   assign last_cmp   = tap_vld && (cmp_idx_q == n_q - CNT_WIDTH'(1));

   // Next error count: cleared on start, saturating increment on mismatch.
   always_comb begin
      err_d = err_count_o;
      if (start_ok)
         err_d = '0;
      else if (mism && (err_count_o != '1))
         err_d = err_count_o + CNT_WIDTH'(1);
   end

   // Next-state logic for the run sequencer.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start_i) state_d = (num_samples_i == '0) ? S_DONE : S_RUN;
         S_RUN:   if (last_issue) state_d = S_DRAIN;
         S_DRAIN: if (last_cmp) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State register plus the registered busy/done flags derived from next state.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         busy_o  <= 1'b0;
         done_o  <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_o  <= (state_d == S_RUN) || (state_d == S_DRAIN);
         done_o  <= (state_d == S_DONE);
      end
   end

   // Stimulus generator: seed on start, +1 per RUN cycle, 0 outside RUN.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stim_o <= '0;
         k_q    <= '0;
         n_q    <= '0;
      end else begin
         if (start_ok) begin
            n_q <= num_samples_i;
            k_q <= '0;
         end else if (state_q == S_RUN) begin
            k_q <= k_q + CNT_WIDTH'(1);
         end
         if (state_d == S_RUN)
            stim_o <= start_ok ? seed_i : stim_o + WIDTH'(1);
         else
            stim_o <= '0;
      end
   end

   // Delay line carrying each issued sample to the comparison tap.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vld_pipe  <= '0;
         stim_pipe <= '0;
      end else begin
         vld_pipe[0]  <= (state_q == S_RUN);
         stim_pipe[0] <= stim_o;
         for (int i = 1; i < LATENCY; i++) begin
            vld_pipe[i]  <= vld_pipe[i-1];
            stim_pipe[i] <= stim_pipe[i-1];
         end
      end
   end

   // Result status: error count, first mismatch capture, pass verdict.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cmp_idx_q        <= '0;
         err_count_o      <= '0;
         first_err_idx_o  <= '0;
         first_err_data_o <= '0;
         pass_o           <= 1'b0;
      end else begin
         err_count_o <= err_d;
         if (start_ok) begin
            cmp_idx_q        <= '0;
            first_err_idx_o  <= '0;
            first_err_data_o <= '0;
         end else begin
            if (tap_vld)
               cmp_idx_q <= cmp_idx_q + CNT_WIDTH'(1);
            // A zero count before this mismatch means it is the run's first.
            if (mism && (err_count_o == '0)) begin
               first_err_idx_o  <= cmp_idx_q;
               first_err_data_o <= resp_i;
            end
         end
         // Verdict uses the post-compare count so it is valid with done_o.
         if (state_d == S_DONE)
            pass_o <= (err_d == '0);
         else if (start_ok)
            pass_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_inc_stream_checker.sv
// Bench for inc_stream_checker: a LATENCY=1 instance looped through a
// registered +1 stage with error injection, and a LATENCY=4 instance
// looped through a 4-stage +1 pipeline.
module tb_inc_stream_checker;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        start1 = 1'b0, start4 = 1'b0;
   logic [13:0] seed1 = '0, seed4 = '0;
   logic [31:0] n1 = '0, n4 = '0;
   logic [13:0] stim1, stim4, resp1, resp4;
   logic        busy1, busy4, done1, done4, pass1, pass4;
   logic [31:0] err1, err4, fidx1, fidx4;
   logic [13:0] fdat1, fdat4;

   logic        inj = 1'b0;
   logic [13:0] cv  = '0;
   logic [13:0] p4 [3];

   bit          bad  [64];
   int          cval [64];

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   inc_stream_checker #(.WIDTH(14), .LATENCY(1), .CNT_WIDTH(32)) u_dut1 (
      .clk_i(clk), .rst_i(rst), .start_i(start1), .seed_i(seed1),
      .num_samples_i(n1), .stim_o(stim1), .resp_i(resp1), .busy_o(busy1),
      .done_o(done1), .pass_o(pass1), .err_count_o(err1),
      .first_err_idx_o(fidx1), .first_err_data_o(fdat1));

   inc_stream_checker #(.WIDTH(14), .LATENCY(4), .CNT_WIDTH(32)) u_dut4 (
      .clk_i(clk), .rst_i(rst), .start_i(start4), .seed_i(seed4),
      .num_samples_i(n4), .stim_o(stim4), .resp_i(resp4), .busy_o(busy4),
      .done_o(done4), .pass_o(pass4), .err_count_o(err4),
      .first_err_idx_o(fidx4), .first_err_data_o(fdat4));

   // Registered +1 stage with a per-cycle corruption override.
   always_ff @(posedge clk) resp1 <= inj ? cv : stim1 + 14'd1;

   // Four-stage +1 pipeline.
   always_ff @(posedge clk) begin
      p4[0] <= stim4 + 14'd1;
      p4[1] <= p4[0];
      p4[2] <= p4[1];
      resp4 <= p4[2];
   end

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   function automatic bit is_mm(input int sel, input int seed, input int k);
      return (sel == 1) && bad[k] && (cval[k] != ((seed + k + 1) % 16384));
   endfunction

   // One complete run; expectations come from the run parameters alone.
   task automatic run(input int sel, input int seed, input int n, input int poke);
      int lat, dn, fi, errs;
      lat = (sel == 4) ? 4 : 1;
      dn  = (n == 0) ? 0 : n + lat;
      fi  = -1;
      for (int k = n - 1; k >= 0; k--) if (is_mm(sel, seed, k)) fi = k;
      if (sel == 1) begin seed1 = 14'(seed); n1 = n; start1 = 1'b1; end
      else          begin seed4 = 14'(seed); n4 = n; start4 = 1'b1; end
      @(posedge clk); #1;
      for (int c = 0; c <= dn + 1; c++) begin
         start1 = (sel == 1) && (c == poke);
         start4 = (sel == 4) && (c == poke);
         inj = (sel == 1) && (c < n) && bad[c];
         cv  = 14'(cval[c < 64 ? c : 0]);
         errs = 0;
         for (int k = 0; k < n; k++) if (is_mm(sel, seed, k) && (k + lat + 1 <= c)) errs++;
         chk($sformatf("stim%0d c%0d", sel, c), (sel == 1) ? stim1 : stim4,
             (c < n) ? (seed + c) % 16384 : 0);
         chk($sformatf("busy%0d c%0d", sel, c), (sel == 1) ? busy1 : busy4, (c < dn) ? 1 : 0);
         chk($sformatf("done%0d c%0d", sel, c), (sel == 1) ? done1 : done4, (c == dn) ? 1 : 0);
         chk($sformatf("err%0d c%0d", sel, c), (sel == 1) ? err1 : err4, errs);
         if (c >= dn) begin
            chk($sformatf("pass%0d c%0d", sel, c), (sel == 1) ? pass1 : pass4, (fi < 0) ? 1 : 0);
            chk($sformatf("fidx%0d c%0d", sel, c), (sel == 1) ? fidx1 : fidx4, (fi < 0) ? 0 : fi);
            chk($sformatf("fdat%0d c%0d", sel, c), (sel == 1) ? fdat1 : fdat4,
                (fi < 0) ? 0 : cval[fi]);
         end
         @(posedge clk); #1;
      end
      start1 = 1'b0; start4 = 1'b0; inj = 1'b0;
   endtask

   task automatic clear_bad();
      for (int k = 0; k < 64; k++) begin bad[k] = 1'b0; cval[k] = 0; end
   endtask

   initial begin
      clear_bad();
      repeat (3) @(posedge clk);
      #1;
      chk("rst stim1", stim1, 0);  chk("rst busy1", busy1, 0); chk("rst done1", done1, 0);
      chk("rst pass1", pass1, 0);  chk("rst err1", err1, 0);   chk("rst fidx1", fidx1, 0);
      chk("rst fdat1", fdat1, 0);  chk("rst stim4", stim4, 0); chk("rst busy4", busy4, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Basic loopback and wrap-around.
      run(1, 100, 10, -1);
      run(1, 16380, 8, -1);

      // Forced-zero responses on samples 3 and 6.
      bad[3] = 1'b1; bad[6] = 1'b1;
      run(1, 500, 10, -1);
      chk("inj err", err1, 2); chk("inj fidx", fidx1, 3); chk("inj fdat", fdat1, 0);
      chk("inj pass", pass1, 0);
      clear_bad();

      // Longer pipeline, empty runs, start pulsed mid-run and in DONE.
      run(4, 7, 5, -1);
      run(1, 33, 0, -1);
      run(4, 33, 0, -1);
      run(1, 50, 10, 4);
      run(4, 16383, 6, 10);

      // Reset at k=2 of a 10-sample run.
      seed1 = 14'd200; n1 = 10; start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("pre-rst stim", stim1, 202);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("mid-rst stim", stim1, 0); chk("mid-rst busy", busy1, 0); chk("mid-rst done", done1, 0);
      chk("mid-rst pass", pass1, 0); chk("mid-rst err", err1, 0);   chk("mid-rst fidx", fidx1, 0);
      chk("mid-rst fdat", fdat1, 0);
      run(1, 0, 3, -1);

      // Randomized runs with random corruption on the LATENCY=1 path.
      for (int r = 0; r < 16; r++) begin
         int sel, nn, pk;
         clear_bad();
         sel = ($urandom_range(0, 2) == 0) ? 4 : 1;
         nn  = $urandom_range(0, 40);
         for (int k = 0; k < 64; k++) begin
            bad[k]  = ($urandom_range(0, 3) == 0);
            cval[k] = $urandom_range(0, 16383);
            if ($urandom_range(0, 7) == 0) cval[k] = 0;
         end
         pk = ($urandom_range(0, 1) == 1) ? $urandom_range(0, nn + ((sel == 4) ? 4 : 1)) : -1;
         if (nn == 0) pk = -1;
         run(sel, $urandom_range(0, 16383), nn, pk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
